// File: rtl/noc_arb_pkg.sv
// Shared types and constants for the NoC per-output wormhole arbiter.
package noc_arb_pkg;

  localparam int unsigned PORT_N = 0;
  localparam int unsigned PORT_E = 1;
  localparam int unsigned PORT_W = 2;
  localparam int unsigned PORT_S = 3;
  localparam int unsigned PORT_L = 4;

  localparam int unsigned FLIT_W = 3;
  localparam int unsigned SEL_W  = 3;

  localparam logic [FLIT_W-1:0] FLIT_HEADER = 3'b001;
  localparam logic [FLIT_W-1:0] FLIT_BODY   = 3'b010;
  localparam logic [FLIT_W-1:0] FLIT_TAIL   = 3'b100;

  typedef enum logic {IDLE, LOCKED} arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first eligible index after rr_ptr, wrapping,
// returned one-hot.
module rr_priority_picker #(
  parameter int unsigned NUM_IN = 5,
  parameter int unsigned PTR_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] eligible,
  input  logic [PTR_W-1:0]  rr_ptr,
  output logic [NUM_IN-1:0] pick_c,
  output logic              any_valid_c
);

  logic [PTR_W-1:0] idx;
  logic             found;

  // Walk candidates rr_ptr+1 .. rr_ptr+NUM_IN; the first hit wins.
  always_comb begin
    pick_c = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= NUM_IN; k++) begin
      idx = PTR_W'((32'(rr_ptr) + k) % NUM_IN);
      if (!found && eligible[idx]) begin
        pick_c[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any_valid_c = |eligible;

endmodule

// File: rtl/lbdr_output_arbiter.sv
// Per-output wormhole switch allocator: header wins the output, tail releases it.
// Optional lock-timeout stall flag built only when ARB_TIMEOUT_EN is defined.
module lbdr_output_arbiter
  import noc_arb_pkg::*;
#(
  parameter int unsigned NUM_IN  = 5,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_IN-1:0]              req,
  input  logic [NUM_IN-1:0]              empty,
  input  logic [NUM_IN-1:0][FLIT_W-1:0]  flit_id,
  input  logic                           credit_ok,
  output logic [NUM_IN-1:0]              grant,
  output logic [SEL_W-1:0]               xbar_sel,
  output logic [NUM_IN-1:0]              xfer,
  output logic                           valid_out,
  output logic                           stall_err
);

  localparam int unsigned PTR_W = $clog2(NUM_IN);

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("lbdr_output_arbiter: TIMEOUT must be nonzero");
  end

  arb_state_t        state_q, state_d;
  logic [NUM_IN-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [NUM_IN-1:0] eligible_c;
  logic [NUM_IN-1:0] pick_c;
  logic              any_valid_c;
  logic [SEL_W-1:0]  pick_idx_c;
  logic              tail_xfer_c;

  // Only a request sitting on a header flit may open a new packet.
  always_comb begin
    eligible_c = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      eligible_c[i] = req[i] & ~empty[i] & (flit_id[i] == FLIT_HEADER);
    end
  end

  rr_priority_picker #(
    .NUM_IN (NUM_IN),
    .PTR_W  (PTR_W)
  ) u_picker (
    .eligible    (eligible_c),
    .rr_ptr      (rr_ptr_q),
    .pick_c      (pick_c),
    .any_valid_c (any_valid_c)
  );

  always_comb begin
    pick_idx_c = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (pick_c[i]) pick_idx_c = SEL_W'(i);
    end
  end

  assign xfer        = grant_q & ~empty & {NUM_IN{credit_ok}};
  assign valid_out   = |xfer;
  assign tail_xfer_c = (state_q == LOCKED) & xfer[sel_q] & (flit_id[sel_q] == FLIT_TAIL);

  // State register; rr_ptr resets to the last input so input 0 is served first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      sel_q    <= '0;
      rr_ptr_q <= PTR_W'(NUM_IN - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (any_valid_c) state_d = LOCKED;
      LOCKED: if (tail_xfer_c) state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d  = grant_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (any_valid_c) begin
          grant_d = pick_c;
          sel_d   = pick_idx_c;
        end else begin
          grant_d = '0;
          sel_d   = '0;
        end
      end
      LOCKED: begin
        if (tail_xfer_c) begin
          grant_d  = '0;
          sel_d    = '0;
          rr_ptr_d = PTR_W'(sel_q);
        end
      end
    endcase
  end

  assign grant    = grant_q;
  assign xbar_sel = sel_q;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_q, stall_d;

  // Counts consecutive locked cycles without a transfer; saturates at TIMEOUT.
  always_comb begin
    cnt_d = '0;
    if (state_q == LOCKED && !valid_out) begin
      cnt_d = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);
    end
    stall_d = stall_q | (cnt_d == CNT_W'(TIMEOUT));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign stall_err = stall_q;
`else
  assign stall_err = 1'b0;
`endif

endmodule

// File: tb/tb_lbdr_output_arbiter.sv
// Randomized bench for lbdr_output_arbiter against a packet-level reference model.
module tb_lbdr_output_arbiter;
  import noc_arb_pkg::*;

  localparam int unsigned N  = 5;
  localparam int unsigned TO = 64;
`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           req;
  logic [N-1:0]           empty;
  logic [N-1:0][2:0]      flit_id;
  logic                   credit_ok;
  logic [N-1:0]           grant;
  logic [2:0]             xbar_sel;
  logic [N-1:0]           xfer;
  logic                   valid_out;
  logic                   stall_err;

  lbdr_output_arbiter #(.NUM_IN(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .empty     (empty),
    .flit_id   (flit_id),
    .credit_ok (credit_ok),
    .grant     (grant),
    .xbar_sel  (xbar_sel),
    .xfer      (xfer),
    .valid_out (valid_out),
    .stall_err (stall_err)
  );

  always #5 clk = ~clk;

  // Per-input source FIFOs (circular, only refilled when drained).
  logic [2:0] fifo [N][64];
  int         rd [N];
  int         wr [N];

  // Stimulus knobs
  bit           rst_drv;
  logic [N-1:0] req_en;
  logic [N-1:0] hold_empty;
  bit           credit_val;
  bit           rand_mode;

  // Reference model state: current owner (-1 = none), last served input, stall tracking
  int owner;
  int last;
  int idle_cnt;
  bit stall_m;

  int compared   = 0;
  int mismatched = 0;
  int vo_cnt     = 0;
  int gstart [$];
  logic [N-1:0] prev_grant = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int qsize(input int i);
    return wr[i] - rd[i];
  endfunction

  task automatic push(input int i, input logic [2:0] f);
    fifo[i][wr[i] % 64] = f;
    wr[i]++;
  endtask

  task automatic add_packet(input int i, input int nbody, input bit allow_bad);
    logic [2:0] b;
    push(i, FLIT_HEADER);
    for (int k = 0; k < nbody; k++) begin
      b = FLIT_BODY;
      if (allow_bad && ($urandom % 5) == 0) begin
        b = 3'($urandom);
        if (b == FLIT_TAIL) b = FLIT_BODY;
      end
      push(i, b);
    end
    push(i, FLIT_TAIL);
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) rd[i] = wr[i];
  endtask

  // One clock cycle: drive at negedge, compare #1 later, then advance the model.
  task automatic cycle();
    logic [N-1:0] exp_grant;
    logic [N-1:0] exp_xfer;
    logic [2:0]   exp_sel;
    int           c;
    bit           found;
    @(negedge clk);
    if (rand_mode) begin
      for (int i = 0; i < N; i++) begin
        req_en[i]     = 1'(($urandom % 5) != 0);
        hold_empty[i] = 1'(($urandom % 7) == 0);
        if (qsize(i) == 0 && ($urandom % 3) == 0) add_packet(i, int'($urandom % 4), 1'b1);
      end
      credit_val = ($urandom % 5) != 0;
    end
    rst = rst_drv;
    for (int i = 0; i < N; i++) begin
      empty[i]   = (qsize(i) == 0) || hold_empty[i];
      flit_id[i] = (qsize(i) > 0) ? fifo[i][rd[i] % 64] : 3'($urandom);
      req[i]     = req_en[i];
    end
    credit_ok = credit_val;
    if (!rst_drv) begin
      owner = -1; last = N - 1; idle_cnt = 0; stall_m = 1'b0;
    end
    #1;
    exp_grant = (owner >= 0) ? (N'(1) << owner) : '0;
    exp_sel   = (owner >= 0) ? 3'(owner) : 3'd0;
    exp_xfer  = exp_grant & ~empty & {N{credit_ok}};
    check_eq("grant",     32'(grant),     32'(exp_grant));
    check_eq("xbar_sel",  32'(xbar_sel),  32'(exp_sel));
    check_eq("xfer",      32'(xfer),      32'(exp_xfer));
    check_eq("valid_out", 32'(valid_out), 32'(exp_xfer != 0));
    check_eq("stall_err", 32'(stall_err), 32'(stall_m & TIMEOUT_ON));
    if (valid_out) vo_cnt++;
    if (grant != 0 && prev_grant == 0) gstart.push_back(int'(xbar_sel));
    prev_grant = grant;
    if (rst_drv) begin
      if (owner < 0) begin
        idle_cnt = 0;
        found    = 1'b0;
        for (int k = 1; k <= N; k++) begin
          c = (last + k) % N;
          if (!found && req[c] && !empty[c] && flit_id[c] == FLIT_HEADER) begin
            owner = c;
            found = 1'b1;
          end
        end
      end else if (exp_xfer != 0) begin
        idle_cnt = 0;
        if (flit_id[owner] == FLIT_TAIL) begin
          last  = owner;
          owner = -1;
        end
      end else begin
        if (idle_cnt < TO) idle_cnt++;
        if (idle_cnt == TO) stall_m = 1'b1;
      end
      for (int i = 0; i < N; i++) if (exp_xfer[i]) rd[i]++;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin rd[i] = 0; wr[i] = 0; end
    owner = -1; last = N - 1; idle_cnt = 0; stall_m = 1'b0;
    rst = 1'b0; rst_drv = 1'b0; rand_mode = 1'b0;
    req_en = '1; hold_empty = '0; credit_val = 1'b1;
    req = '1; empty = '1; flit_id = '0; credit_ok = 1'b1;

    // Reset values with every input requesting on a header
    for (int i = 0; i < N; i++) add_packet(i, 0, 1'b0);
    run(2);
    clear_queues();
    rst_drv = 1'b1;
    run(1);

    // Single packet on W
    req_en = 5'b00100;
    vo_cnt = 0;
    gstart.delete();
    add_packet(PORT_W, 1, 1'b0);
    run(8);
    check_eq("w_pulses", 32'(vo_cnt), 32'd3);
    check_eq("w_first_sel", 32'((gstart.size() > 0) ? gstart[0] : -1), 32'(PORT_W));

    // Round-robin order from reset
    rst_drv = 1'b0;
    run(1);
    rst_drv = 1'b1;
    req_en = '1;
    gstart.delete();
    for (int i = 0; i < N; i++) begin add_packet(i, 0, 1'b0); add_packet(i, 0, 1'b0); end
    run(50);
    check_eq("rr_count", 32'(gstart.size() >= 6), 32'd1);
    for (int k = 0; k < 6; k++) begin
      check_eq("rr_order", 32'((k < gstart.size()) ? gstart[k] : -1), 32'(k % N));
    end

    // Lock hold: E owns, N waits behind empty/credit stalls
    gstart.delete();
    add_packet(PORT_E, 2, 1'b0);
    run(2);
    add_packet(PORT_N, 0, 1'b0);
    hold_empty[PORT_E] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_eq("hold_grant", 32'(grant), 32'h02);
      check_eq("hold_xfer",  32'(xfer),  32'h00);
    end
    hold_empty[PORT_E] = 1'b0;
    credit_val = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_eq("cred_grant", 32'(grant), 32'h02);
      check_eq("cred_xfer",  32'(xfer),  32'h00);
    end
    credit_val = 1'b1;
    run(10);
    check_eq("lock_starts", 32'(gstart.size()), 32'd2);
    check_eq("lock_after",  32'((gstart.size() > 1) ? gstart[1] : -1), 32'(PORT_N));

    // Reset mid-packet on L; afterwards input 0 must win first
    add_packet(PORT_L, 6, 1'b0);
    run(3);
    rst_drv = 1'b0;
    cycle();
    check_eq("rst_mid_grant", 32'(grant), 32'h00);
    clear_queues();
    run(1);
    rst_drv = 1'b1;
    gstart.delete();
    for (int i = 0; i < N; i++) add_packet(i, 0, 1'b0);
    run(4);
    check_eq("rst_first", 32'((gstart.size() > 0) ? gstart[0] : -1), 32'(PORT_N));
    run(30);

    // Randomized traffic, then drain
    rand_mode = 1'b1;
    run(1500);
    rand_mode = 1'b0;
    req_en = '1; hold_empty = '0; credit_val = 1'b1;
    run(80);

    // Lock timeout: owner E starved for longer than TIMEOUT
    rst_drv = 1'b0;
    run(1);
    clear_queues();
    rst_drv = 1'b1;
    add_packet(PORT_E, 1, 1'b0);
    run(2);
    hold_empty[PORT_E] = 1'b1;
    run(70);
    check_eq("stall_set",  32'(stall_err), 32'(TIMEOUT_ON));
    check_eq("stall_lock", 32'(grant),     32'h02);
    hold_empty[PORT_E] = 1'b0;
    run(10);
    check_eq("stall_sticky", 32'(stall_err), 32'(TIMEOUT_ON));
    check_eq("stall_freed",  32'(grant),     32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
